// File: rtl/alu_step_sequencer_if.sv
// Control/datapath bundle between the hardwired step sequencer (master) and the bus datapath (slave).
interface alu_step_sequencer_if #(
    parameter int IR_W      = 32,
    parameter int OPC_W     = 5,
    parameter int REG_SEL_W = 4,
    parameter int CNT_W     = 16
);
    localparam int NUM_REGS = 2 ** REG_SEL_W;

    logic                Run;
    logic [IR_W-1:0]     IR;
    logic                MemReady;

    logic                PCout;
    logic                MARin;
    logic                Zin;
    logic                ZLOout;
    logic                PCin;
    logic                IncrementPC;
    logic                Read;
    logic                MDRin;
    logic                MDRout;
    logic                IRin;
    logic                Yin;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic [OPC_W-1:0]    ALUControl;
    logic                Done;
    logic                Illegal;
    logic                BusError;
    logic [CNT_W-1:0]    InstrCount;

    modport master (
        input  Run, IR, MemReady,
        output PCout, MARin, Zin, ZLOout, PCin, IncrementPC, Read, MDRin, MDRout, IRin, Yin,
        output Rin, Rout, ALUControl, Done, Illegal, BusError, InstrCount
    );

    modport slave (
        output Run, IR, MemReady,
        input  PCout, MARin, Zin, ZLOout, PCin, IncrementPC, Read, MDRin, MDRout, IRin, Yin,
        input  Rin, Rout, ALUControl, Done, Illegal, BusError, InstrCount
    );
endinterface

// File: rtl/alu_step_sequencer.sv
// Hardwired control-step sequencer: fetch (T0-T2) with memory-ready wait and timeout, then
// three-register ALU execute (T3-T5) with one-hot register selects decoded from IR.
module alu_step_sequencer #(
    parameter int IR_W        = 32,
    parameter int OPC_W       = 5,
    parameter int REG_SEL_W   = 4,
    parameter int ALU_OPS     = 16,
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    alu_step_sequencer_if.master bus
);
    localparam int NUM_REGS = 2 ** REG_SEL_W;
    localparam int WC_W     = $clog2(MEM_TIMEOUT + 1);

    localparam logic [WC_W-1:0]     WC_ZERO_C    = {WC_W{1'b0}};
    localparam logic [WC_W-1:0]     WC_ONE_C     = WC_W'(1);
    localparam logic [WC_W-1:0]     WC_TIMEOUT_C = WC_W'(MEM_TIMEOUT);
    localparam logic [OPC_W:0]      ALU_OPS_C    = (OPC_W + 1)'(ALU_OPS);
    localparam logic [NUM_REGS-1:0] SEL_ZERO_C   = {NUM_REGS{1'b0}};
    localparam logic [NUM_REGS-1:0] SEL_ONE_C    = NUM_REGS'(1);
    localparam logic [OPC_W-1:0]    OPC_ZERO_C   = {OPC_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]    CNT_ONE_C    = CNT_W'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;

    logic [2:0]           state_q,       state_d;
    logic [WC_W-1:0]      wait_cnt_q,    wait_cnt_d;
    logic                 bus_error_q,   bus_error_d;
    logic [CNT_W-1:0]     instr_count_q, instr_count_d;

    logic [OPC_W-1:0]     opcode_s;
    logic [REG_SEL_W-1:0] ra_s;
    logic [REG_SEL_W-1:0] rb_s;
    logic [REG_SEL_W-1:0] rc_s;
    logic                 legal_s;
    logic [WC_W-1:0]      wait_cnt_inc_s;

    // Fields are packed MSB-first: opcode, Ra, Rb, Rc
    assign opcode_s       = bus.IR[IR_W-1 -: OPC_W];
    assign ra_s           = bus.IR[IR_W-OPC_W-1 -: REG_SEL_W];
    assign rb_s           = bus.IR[IR_W-OPC_W-REG_SEL_W-1 -: REG_SEL_W];
    assign rc_s           = bus.IR[IR_W-OPC_W-2*REG_SEL_W-1 -: REG_SEL_W];
    assign legal_s        = ({1'b0, opcode_s} < ALU_OPS_C);
    assign wait_cnt_inc_s = wait_cnt_q + WC_ONE_C;

    assign bus.BusError   = bus_error_q;
    assign bus.InstrCount = instr_count_q;

    // Next-state, wait-counter, bus-error and retire-count computation
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        bus_error_d   = bus_error_q;
        instr_count_d = instr_count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Run && !bus_error_q) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T0: begin
                state_d    = S_T1;
                wait_cnt_d = WC_ZERO_C;
            end
            S_T1: begin
                if (bus.MemReady) begin
                    state_d = S_T2;
                end else if (wait_cnt_inc_s == WC_TIMEOUT_C) begin
                    wait_cnt_d  = wait_cnt_inc_s;
                    bus_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_inc_s;
                    state_d    = S_T1;
                end
            end
            S_T2: begin
                state_d = S_T3;
            end
            S_T3: begin
                // An illegal opcode ends the instruction here, without retiring it
                if (legal_s) begin
                    state_d = S_T4;
                end else if (bus.Run) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T4: begin
                state_d = S_T5;
            end
            S_T5: begin
                instr_count_d = instr_count_q + CNT_ONE_C;
                if (bus.Run) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore strobe decode; execute-step selects follow the live IR fields
    always_comb begin
        bus.PCout       = 1'b0;
        bus.MARin       = 1'b0;
        bus.Zin         = 1'b0;
        bus.ZLOout      = 1'b0;
        bus.PCin        = 1'b0;
        bus.IncrementPC = 1'b0;
        bus.Read        = 1'b0;
        bus.MDRin       = 1'b0;
        bus.MDRout      = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Rin         = SEL_ZERO_C;
        bus.Rout        = SEL_ZERO_C;
        bus.ALUControl  = OPC_ZERO_C;
        bus.Done        = 1'b0;
        bus.Illegal     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.Done = 1'b0;
            end
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.Zin   = 1'b1;
            end
            S_T1: begin
                bus.ZLOout      = 1'b1;
                bus.PCin        = 1'b1;
                bus.IncrementPC = 1'b1;
                bus.Read        = 1'b1;
                bus.MDRin       = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (legal_s) begin
                    bus.Rout = SEL_ONE_C << rb_s;
                    bus.Yin  = 1'b1;
                end else begin
                    bus.Illegal = 1'b1;
                end
            end
            S_T4: begin
                bus.Rout       = SEL_ONE_C << rc_s;
                bus.Zin        = 1'b1;
                bus.ALUControl = opcode_s;
            end
            S_T5: begin
                bus.ZLOout = 1'b1;
                bus.Rin    = SEL_ONE_C << ra_s;
                bus.Done   = 1'b1;
            end
            default: begin
                bus.Done = 1'b0;
            end
        endcase
    end

    // Sequencer state registers; Reset overrides everything, including a sticky bus error
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= WC_ZERO_C;
            bus_error_q   <= 1'b0;
            instr_count_q <= CNT_ZERO_C;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_error_q   <= bus_error_d;
            instr_count_q <= instr_count_d;
        end
    end
endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench: each instruction is expanded into its expected per-cycle step trace, and one
// negedge process compares every DUT output against that trace.
module tb_alu_step_sequencer;
    localparam int IR_W        = 32;
    localparam int OPC_W       = 5;
    localparam int REG_SEL_W   = 4;
    localparam int ALU_OPS     = 16;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 16;

    localparam logic [31:0] IR_LEGAL = 32'h2822_8000;
    localparam logic [31:0] IR_SAME  = {5'd15, 4'd7, 4'd7, 4'd7, 15'd0};
    localparam logic [31:0] IR_B     = {5'd0, 4'd15, 4'd1, 4'd2, 15'd0};
    localparam logic [31:0] IR_C     = {5'd9, 4'd3, 4'd12, 4'd0, 15'd0};
    localparam logic [31:0] IR_ILL   = {5'b11111, 4'd2, 4'd3, 4'd4, 15'd0};
    localparam logic [31:0] IR_ILL16 = {5'd16, 4'd1, 4'd1, 4'd1, 15'd0};

    // strb bits: PCout MARin Zin ZLOout PCin IncrementPC Read MDRin MDRout IRin Yin
    typedef struct packed {
        logic [10:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        done;
        logic        illegal;
        logic        buserr;
        logic [15:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    obs_t exp_q[$];
    obs_t cmp_exp;
    obs_t cmp_got;
    logic [15:0] m_count;
    logic        m_buserr;

    alu_step_sequencer_if #(.IR_W(IR_W), .OPC_W(OPC_W), .REG_SEL_W(REG_SEL_W), .CNT_W(CNT_W)) bus ();

    alu_step_sequencer #(
        .IR_W(IR_W), .OPC_W(OPC_W), .REG_SEL_W(REG_SEL_W),
        .ALU_OPS(ALU_OPS), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    // Expected outputs for one step (-1 = idle, 0..5 = T0..T5) of an instruction
    function automatic obs_t expect_step(input int t, input logic [31:0] ir);
        obs_t e;
        logic [4:0] opc;
        e        = '0;
        opc      = ir[31:27];
        e.buserr = m_buserr;
        e.cnt    = m_count;
        case (t)
            0: e.strb = 11'b111_0000_0000;
            1: e.strb = 11'b000_1111_1000;
            2: e.strb = 11'b000_0000_0110;
            3: begin
                if (opc < 5'd16) begin
                    e.strb = 11'b000_0000_0001;
                    e.rout = 16'd1 << ir[22:19];
                end else begin
                    e.illegal = 1'b1;
                end
            end
            4: begin
                e.strb = 11'b001_0000_0000;
                e.rout = 16'd1 << ir[18:15];
                e.alu  = opc;
            end
            5: begin
                e.strb = 11'b000_1000_0000;
                e.rin  = 16'd1 << ir[26:23];
                e.done = 1'b1;
            end
            default: e.strb = 11'b000_0000_0000;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input int t);
        exp_q.push_back(expect_step(t, bus.IR));
    endtask

    task automatic idle_cycle(input logic run);
        bus.Run      = run;
        bus.MemReady = 1'b0;
        expect_now(-1);
        tick();
    endtask

    // Two reset cycles with Run high, then Reset falls; returns at the first T0 cycle
    task automatic do_reset();
        rst          = 1'b1;
        bus.Run      = 1'b1;
        bus.MemReady = 1'b0;
        tick();
        m_count  = 16'd0;
        m_buserr = 1'b0;
        expect_now(-1);
        tick();
        rst = 1'b0;
        expect_now(-1);
        tick();
    endtask

    // Called on a T0 cycle; runs one instruction with nstall low-MemReady T1 cycles
    task automatic run_instr(input logic [31:0] ir, input int nstall, input logic run_end,
                             input bit abort_t4);
        bus.IR       = ir;
        bus.Run      = run_end;
        bus.MemReady = 1'b0;
        expect_now(0);
        tick();
        for (int i = 0; i <= nstall; i++) begin
            bus.MemReady = (i == nstall);
            expect_now(1);
            tick();
        end
        bus.MemReady = 1'b0;
        expect_now(2);
        tick();
        expect_now(3);
        tick();
        if (ir[31:27] >= 5'd16) return;
        expect_now(4);
        if (abort_t4) begin
            rst = 1'b1;
            tick();
            rst      = 1'b0;
            bus.Run  = 1'b0;
            m_count  = 16'd0;
            m_buserr = 1'b0;
            return;
        end
        tick();
        expect_now(5);
        tick();
        m_count = m_count + 16'd1;
    endtask

    task automatic timeout_instr(input logic [31:0] ir);
        bus.IR       = ir;
        bus.Run      = 1'b1;
        bus.MemReady = 1'b0;
        expect_now(0);
        tick();
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            expect_now(1);
            tick();
        end
        m_buserr = 1'b1;
    endtask

    // Single per-cycle comparison of every DUT output against the queued trace
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            cmp_exp = exp_q.pop_front();
            cmp_got.strb    = {bus.PCout, bus.MARin, bus.Zin, bus.ZLOout, bus.PCin, bus.IncrementPC,
                               bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin};
            cmp_got.rin     = bus.Rin;
            cmp_got.rout    = bus.Rout;
            cmp_got.alu     = bus.ALUControl;
            cmp_got.done    = bus.Done;
            cmp_got.illegal = bus.Illegal;
            cmp_got.buserr  = bus.BusError;
            cmp_got.cnt     = bus.InstrCount;
            n_tests++;
            if (cmp_got !== cmp_exp) begin
                n_fail++;
                $display("FAIL trace cyc=%0d ir=%h got strb=%b rin=%h rout=%h alu=%0d done=%b ill=%b berr=%b cnt=%0d; expected strb=%b rin=%h rout=%h alu=%0d done=%b ill=%b berr=%b cnt=%0d",
                         cyc, bus.IR,
                         cmp_got.strb, cmp_got.rin, cmp_got.rout, cmp_got.alu, cmp_got.done,
                         cmp_got.illegal, cmp_got.buserr, cmp_got.cnt,
                         cmp_exp.strb, cmp_exp.rin, cmp_exp.rout, cmp_exp.alu, cmp_exp.done,
                         cmp_exp.illegal, cmp_exp.buserr, cmp_exp.cnt);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.Run      = 1'b0;
        bus.MemReady = 1'b0;
        bus.IR       = 32'd0;
        m_count      = 16'd0;
        m_buserr     = 1'b0;

        // Hand-computed values pinning the model for IR=0x28228000
        check("pin_t3_rout", 32'(expect_step(3, IR_LEGAL).rout), 32'h0010);
        check("pin_t4_rout", 32'(expect_step(4, IR_LEGAL).rout), 32'h0020);
        check("pin_t4_alu",  32'(expect_step(4, IR_LEGAL).alu),  32'd5);
        check("pin_t5_rin",  32'(expect_step(5, IR_LEGAL).rin),  32'h0001);
        check("pin_ill_t3",  32'(expect_step(3, IR_ILL).illegal), 32'd1);

        do_reset();
        check("reset_cnt", 32'(bus.InstrCount), 32'd0);
        run_instr(IR_LEGAL, 0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("cnt_after_legal", 32'(bus.InstrCount), 32'd1);

        idle_cycle(1'b1);
        run_instr(IR_B, 3, 1'b0, 1'b0);
        idle_cycle(1'b1);
        run_instr(IR_ILL16, 0, 1'b1, 1'b0);
        run_instr(IR_ILL, 0, 1'b1, 1'b0);
        run_instr(IR_C, 0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        check("cnt_after_illegal", 32'(bus.InstrCount), 32'd3);

        do_reset();
        run_instr(IR_LEGAL, 0, 1'b1, 1'b0);
        run_instr(IR_SAME, 0, 1'b1, 1'b0);
        run_instr(IR_C, 1, 1'b1, 1'b0);
        check("cnt_b2b", 32'(bus.InstrCount), 32'd3);
        run_instr(IR_B, 0, 1'b1, 1'b1);
        check("cnt_after_abort", 32'(bus.InstrCount), 32'd0);
        check("rout_after_abort", 32'(bus.Rout), 32'd0);
        idle_cycle(1'b0);

        idle_cycle(1'b1);
        timeout_instr(IR_LEGAL);
        check("buserr_set", 32'(bus.BusError), 32'd1);
        for (int i = 0; i < 4; i++) idle_cycle(1'b1);

        do_reset();
        check("buserr_clear", 32'(bus.BusError), 32'd0);
        run_instr(IR_SAME, 0, 1'b0, 1'b0);
        idle_cycle(1'b0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_step_sequencer.md
# alu_step_sequencer

Parametrised hardwired control-step sequencer for the phase-1 bus datapath. It drives the fetch/execute strobes (PCout, MARin, Zin, ZLOout, PCin, IncrementPC, Read, MDRin, MDRout, IRin, Yin, register in/out selects, ALUControl) that are currently hand-sequenced per step. It decodes three-register ALU instructions from IR into one-hot register selects. It adds a memory-ready handshake with timeout, illegal-opcode detection, back-to-back execution and a retired-instruction counter.

## Interface
- IR_W, 32: instruction register width
- OPC_W, 5: opcode field width
- REG_SEL_W, 4: register-field width; NUM_REGS = 2**REG_SEL_W
- ALU_OPS, 16: opcodes 0..ALU_OPS-1 are legal ALU ops
- MEM_TIMEOUT, 8: maximum T1 wait cycles for MemReady (must be ≥1)
- CNT_W, 16: retired-instruction counter width
- Constraint: OPC_W + 3*REG_SEL_W ≤ IR_W

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  synchronous, active-high
- Run  in  1  start / continue execution
- IR  in  IR_W  current instruction register contents
- MemReady  in  1  memory read data valid on Mdatain
- PCout, MARin, Zin, ZLOout, PCin, IncrementPC, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
- Rin  out  NUM_REGS  one-hot register load select
- Rout  out  NUM_REGS  one-hot register drive select
- ALUControl  out  OPC_W  ALU operation select
- Done  out  1  one-cycle pulse when an instruction retires
- Illegal  out  1  one-cycle pulse on an illegal opcode
- BusError  out  1  sticky memory timeout flag
- InstrCount  out  CNT_W  retired-instruction count

## Operation
- Fields are taken MSB-first: opcode = IR[IR_W-1 -: OPC_W], then Ra, Rb and Rc, each REG_SEL_W bits wide.
- States are IDLE, T0, T1, T2, T3, T4, T5. Outputs are Moore-decoded from state; any strobe not listed for a state is 0.
- IDLE: all strobes 0. Moves to T0 when Run=1 and BusError=0.
- T0: PCout, MARin, Zin. Always moves to T1.
- T1: ZLOout, PCin, IncrementPC, Read, MDRin.
  - Moves to T2 on MemReady=1.
  - Otherwise stays in T1 with the strobes held.
  - When the wait counter reaches MEM_TIMEOUT cycles with no MemReady: set BusError and go to IDLE.
- T2: MDRout, IRin. IR is valid from T3 onward.
- T3, legal opcode: Rout[Rb], Yin.
- T3, opcode ≥ ALU_OPS: no strobes; Illegal=1 for that cycle; then behaves as the end of T5 without Done and without a count increment.
- T4: Rout[Rc], Zin, ALUControl=opcode. ALUControl is 0 in every other state.
- T5: ZLOout, Rin[Ra], Done=1. InstrCount increments, wrapping at 2**CNT_W.
- After T5: goes to T0 if Run=1, otherwise IDLE.
- Run is sampled only in IDLE and at the end of T5/T3-illegal. Deasserting Run mid-instruction lets the current instruction complete.
- Ra=Rb=Rc is legal; selects follow the fields exactly.
- BusError clears only on Reset.

## Timing
- Reset (synchronous, takes priority over all else) forces IDLE on the next edge: all strobes 0, Rin=Rout=0, ALUControl=0, Done=0, Illegal=0, BusError=0, InstrCount=0, wait counter 0.
- Reset asserted mid-instruction aborts it; no Done and no count increment.
- Nominal instruction (MemReady=1 in the first T1 cycle): 6 cycles, T0 through T5.
- Each MemReady=0 cycle in T1 adds 1 cycle.
- Back-to-back instructions with Run held high: T5 is followed directly by T0, with no IDLE bubble.
- Illegal-opcode instruction: 4 cycles, T0 through T3.
- Wait counter is cleared on entry to T1 and counts T1 cycles with MemReady=0. BusError asserts on the edge where the count equals MEM_TIMEOUT; the state is IDLE in the same cycle BusError is first visible.
- Done and Illegal are never high simultaneously; Done is high only in T5.

## Test plan
- Reset: hold Reset 2 cycles with Run=1 → all outputs 0, InstrCount=0, state IDLE; first T0 appears on the cycle after Reset falls.
- Legal op: IR=0x28228000 (op 5, Ra=0, Rb=4, Rc=5), MemReady=1, Run pulsed once →
  - T3: Rout=16'h0010, Yin=1
  - T4: Rout=16'h0020, ALUControl=5, Zin=1
  - T5: Rin=16'h0001, Done=1
  - InstrCount=1; 6 cycles total; then IDLE.
- Stall: MemReady low for 3 T1 cycles → T1 strobes held 4 cycles, instruction takes 9 cycles, no BusError.
- Timeout: MEM_TIMEOUT=8, MemReady held 0 → BusError=1 after 8 T1 cycles, IDLE; Run=1 afterwards gives no T0 until Reset.
- Illegal: IR opcode 5'b11111 → Illegal pulse in T3, no Yin/Rin, InstrCount unchanged, next T0 if Run=1.
- Back-to-back: Run=1 for 3 instructions → T5→T0 with no bubble, InstrCount=3. Then Reset during T4 of a fourth → next cycle all outputs 0, InstrCount=0.
